// File: rtl/tone_mon_pkg.sv
// tone_mon_pkg: shared FSM state encoding and default widths for the tone monitor.
package tone_mon_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_SMPL_W = 16;
    localparam int DEF_PER_W  = 8;
    localparam int DEF_ERR_W  = 16;
    localparam int DEF_LEN_W  = 16;
endpackage

// File: rtl/tone_ch_meter.sv
// tone_ch_meter: per-channel zero-crossing, period, peak and error counting.
// Optional trough check enabled by macro TONE_MON_TROUGH_EN.
module tone_ch_meter
    import tone_mon_pkg::*;
#(
    parameter int SMPL_W = DEF_SMPL_W,
    parameter int PER_W  = DEF_PER_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld,
    input  logic                     i_clr,
    input  logic                     i_meas,
    input  logic signed [SMPL_W-1:0] i_smpl,
    input  logic [3:0]               i_settle_xings,
    input  logic [PER_W-1:0]         i_per_min,
    input  logic [PER_W-1:0]         i_per_max,
    input  logic signed [SMPL_W-1:0] i_ampl_min,
    input  logic signed [SMPL_W-1:0] i_ampl_max,
    output logic                     o_settled,
    output logic [ERR_W-1:0]         o_freq_err,
    output logic [ERR_W-1:0]         o_ampl_err,
    output logic [PER_W-1:0]         o_last_per,
    output logic signed [SMPL_W-1:0] o_last_pk
);
    logic signed [SMPL_W-1:0] r_prev, r_pk, r_last_pk;
    logic [PER_W-1:0]         r_cnt, r_last_per;
    logic [ERR_W-1:0]         r_freq_err, r_ampl_err;
    logic [3:0]               r_settle;
    logic                     w_xing, w_per_bad, w_ampl_bad;
    logic [PER_W-1:0]         w_per;

    assign w_xing    = i_vld && r_prev[SMPL_W-1] && !i_smpl[SMPL_W-1];
    assign w_per     = &r_cnt ? r_cnt : r_cnt + PER_W'(1);
    assign w_per_bad = w_per < i_per_min || w_per > i_per_max;
`ifdef TONE_MON_TROUGH_EN
    logic signed [SMPL_W-1:0] r_tr;
    logic signed [SMPL_W:0]   w_neg_tr, w_amin, w_amax;
    // Negate in one extra bit so the most negative sample cannot wrap.
    assign w_neg_tr   = -$signed({r_tr[SMPL_W-1], r_tr});
    assign w_amin     = $signed({i_ampl_min[SMPL_W-1], i_ampl_min});
    assign w_amax     = $signed({i_ampl_max[SMPL_W-1], i_ampl_max});
    assign w_ampl_bad = r_pk < i_ampl_min || r_pk > i_ampl_max || w_neg_tr < w_amin || w_neg_tr > w_amax;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_tr <= '0;
        else if (i_vld)
            r_tr <= (w_xing || i_smpl < r_tr) ? i_smpl : r_tr;
`else
    assign w_ampl_bad = r_pk < i_ampl_min || r_pk > i_ampl_max;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_pk       <= '0;
            r_cnt      <= '0;
            r_last_per <= '0;
            r_last_pk  <= '0;
            r_freq_err <= '0;
            r_ampl_err <= '0;
            r_settle   <= '0;
        end else begin
            if (i_vld) begin
                r_prev <= i_smpl;
                r_cnt  <= w_xing ? '0 : w_per;
                r_pk   <= (w_xing || i_smpl > r_pk) ? i_smpl : r_pk;
            end
            if (w_xing) begin
                r_last_per <= w_per;
                r_last_pk  <= r_pk;
            end
            if (i_clr) begin
                r_settle   <= '0;
                r_freq_err <= '0;
                r_ampl_err <= '0;
            end else if (w_xing) begin
                if (!o_settled)
                    r_settle <= r_settle + 4'd1;
                if (i_meas && w_per_bad && !(&r_freq_err))
                    r_freq_err <= r_freq_err + ERR_W'(1);
                if (i_meas && w_ampl_bad && !(&r_ampl_err))
                    r_ampl_err <= r_ampl_err + ERR_W'(1);
            end
        end
    end

    assign o_settled  = r_settle >= i_settle_xings;
    assign o_freq_err = r_freq_err;
    assign o_ampl_err = r_ampl_err;
    assign o_last_per = r_last_per;
    assign o_last_pk  = r_last_pk;
endmodule

// File: rtl/tone_monitor.sv
// tone_monitor: multi-channel tone test sequencer (settle, measure, done).
// Define TONE_MON_TROUGH_EN to add negative-trough amplitude checking per channel.
module tone_monitor
    import tone_mon_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SMPL_W = DEF_SMPL_W,
    parameter int PER_W  = DEF_PER_W,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic                          i_smpl_vld,
    input  logic [NUM_CH-1:0][SMPL_W-1:0] i_smpl,
    input  logic [3:0]                    i_settle_xings,
    input  logic [LEN_W-1:0]              i_test_len,
    input  logic [PER_W-1:0]              i_per_min,
    input  logic [PER_W-1:0]              i_per_max,
    input  logic [SMPL_W-1:0]             i_ampl_min,
    input  logic [SMPL_W-1:0]             i_ampl_max,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [NUM_CH-1:0][ERR_W-1:0]  o_freq_err,
    output logic [NUM_CH-1:0][ERR_W-1:0]  o_ampl_err,
    output logic [NUM_CH-1:0][PER_W-1:0]  o_last_per,
    output logic [NUM_CH-1:0][SMPL_W-1:0] o_last_pk
);
    state_t             r_state, w_next;
    logic [LEN_W-1:0]   r_len_cnt, w_len_inc;
    logic [NUM_CH-1:0]  w_settled;
    logic               w_clr, w_meas;

    assign w_clr     = r_state == S_IDLE && i_start;
    assign w_meas    = r_state == S_MEASURE;
    assign w_len_inc = r_len_cnt + LEN_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_ch_meter #(.SMPL_W(SMPL_W), .PER_W(PER_W), .ERR_W(ERR_W)) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_vld          (i_smpl_vld),
            .i_clr          (w_clr),
            .i_meas         (w_meas),
            .i_smpl         (i_smpl[c]),
            .i_settle_xings (i_settle_xings),
            .i_per_min      (i_per_min),
            .i_per_max      (i_per_max),
            .i_ampl_min     (i_ampl_min),
            .i_ampl_max     (i_ampl_max),
            .o_settled      (w_settled[c]),
            .o_freq_err     (o_freq_err[c]),
            .o_ampl_err     (o_ampl_err[c]),
            .o_last_per     (o_last_per[c]),
            .o_last_pk      (o_last_pk[c])
        );
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = i_settle_xings == 4'd0 ? S_MEASURE : S_SETTLE;
            S_SETTLE:  if (&w_settled) w_next = S_MEASURE;
            S_MEASURE: if (i_test_len == '0 || (i_smpl_vld && w_len_inc == i_test_len)) w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_len_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_len_cnt <= !w_meas ? '0 : i_smpl_vld ? w_len_inc : r_len_cnt;
        end
    end

    assign o_busy = r_state == S_SETTLE || r_state == S_MEASURE;
    assign o_done = r_state == S_DONE;
endmodule

// File: doc/tone_monitor.md
TONE_MONITOR -- requirements
Module: tone_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of audio channels monitored.
REQ-002 SHALL have parameter SMPL_W, default 16, signed sample width.
REQ-003 SHALL have parameter PER_W, default 8, period counter width; ERR_W, default 16, error counter width; LEN_W, default 16, test length width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse, begins a test run.
REQ-006 smpl_vld  in  1  one-cycle strobe, new sample set present on smpl.
REQ-007 smpl  in  NUM_CH x SMPL_W  signed samples, one per channel.
REQ-008 settle_xings  in  4  crossings per channel ignored before measuring; test_len  in  LEN_W  smpl_vld strobes in measure phase.
REQ-009 per_min, per_max  in  PER_W each  inclusive legal period in samples; ampl_min, ampl_max  in  SMPL_W each  inclusive legal positive peak.
REQ-010 busy  out  1; done  out  1  one-cycle pulse at run end.
REQ-011 freq_err, ampl_err  out  NUM_CH x ERR_W  per-channel error counts; last_per  out  NUM_CH x PER_W; last_pk  out  NUM_CH x SMPL_W.

Function
REQ-012 Zero crossing SHALL be detected per channel on a smpl_vld strobe when previous stored sample is negative and current sample is non-negative; previous sample register updates on every smpl_vld.
REQ-013 Per channel, period counter SHALL increment on each smpl_vld, saturating at all-ones; at a crossing the checked period SHALL be counter+1 (saturating) and counter SHALL clear to 0.
REQ-014 Per channel, peak register SHALL hold max of samples since previous crossing; at a crossing it SHALL be reloaded with the crossing sample.
REQ-015 FSM states IDLE, SETTLE, MEASURE, DONE; IDLE->SETTLE on start (IDLE->MEASURE if settle_xings==0).
REQ-016 SETTLE->MEASURE once every channel has seen settle_xings crossings; per-channel settle counts saturate at settle_xings.
REQ-017 MEASURE SHALL count smpl_vld strobes; ->DONE on the strobe making count equal test_len; test_len==0 -> DONE the cycle after entry.
REQ-018 In MEASURE, each crossing (including one on the final strobe) SHALL increment freq_err if period < per_min or > per_max, and ampl_err if peak < ampl_min or > ampl_max; both may increment on the same crossing.
REQ-019 Error counters SHALL saturate at all-ones and update one cycle after the triggering smpl_vld.
REQ-020 last_per/last_pk SHALL update at every crossing in any state, one cycle after the strobe.
REQ-021 DONE SHALL assert done for one cycle then return to IDLE; busy SHALL be 1 in SETTLE and MEASURE only.
REQ-022 start while busy SHALL be ignored; start in IDLE SHALL clear error counters and settle counts.
REQ-023 Error counters SHALL hold their values in IDLE until next accepted start.

Reset
REQ-024 On rst_n low: FSM IDLE; busy, done, all counters, last_per, last_pk, peak and previous-sample registers 0.
REQ-025 Reset asserted mid-run SHALL abort immediately with no done pulse.

Configuration
REQ-026 Macro TONE_MON_TROUGH_EN defined: each channel SHALL also track minimum sample since previous crossing and increment ampl_err if -trough < ampl_min or > ampl_max (one increment per crossing max); undefined: no trough logic, behaviour per REQ-018 only.

Structure
REQ-027 Package tone_mon_pkg SHALL hold FSM state enum and default widths.
REQ-028 Per-channel detection, counting, peak and error logic SHALL be sub-module tone_ch_meter, instantiated NUM_CH times by generate.

Verification
REQ-029 Sine period 5 samples, peak 1000, limits per 3..7, ampl 750..1250, settle 10, test_len 2000 -> freq_err=ampl_err=0, done once.
REQ-030 Same run, channel 1 peak 1400 -> ampl_err[1]= crossings in measure (~400), ampl_err[0]=0.
REQ-031 Channel 0 period 12 samples -> freq_err[0] = every measure crossing; last_per[0]=12.
REQ-032 Constant positive input 300 strobes, PER_W=8 -> no crossings, run never leaves SETTLE; busy stays 1; start pulses ignored.
REQ-033 rst_n low at strobe 1000 of MEASURE -> all outputs 0, no done; new start after release runs cleanly.
REQ-034 settle_xings=0, test_len=0 -> done pulses 2 cycles after start, counters 0.
